c3po_pack: RTL and testbench

- Reverse direction of the c3po narrow output path: accepts 32-byte beats (sop/eop/val/vbc/data) and repacks them into 160-byte wide words in the c3po input format (sop/eop/val/vbc/id/data).
- Used as the loopback/reassembly stage so narrow-side traffic can be re-injected or scoreboarded at the wide interface.
- Single clock, one output holding register, downstream backpressure.

---
 rtl/c3po_pkg.sv | 35 +++
 rtl/c3po_sat_cnt.sv | 23 ++
 rtl/c3po_pack.sv | 140 ++++++++++++++
 tb/tb_c3po_pack.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c3po_pkg.sv
// Shared constants, types and helpers for the c3po narrow-to-wide repacking path.
package c3po_pkg;

    localparam int unsigned NARROW_BYTES = 32;
    localparam int unsigned WIDE_BYTES   = 160;
    localparam int unsigned BEATS_P      = WIDE_BYTES / NARROW_BYTES;
    localparam int unsigned NARROW_BITS  = NARROW_BYTES * 8;
    localparam int unsigned WIDE_BITS    = WIDE_BYTES * 8;

    typedef enum logic [0:0] {IDLE, IN_PKT} state_e;

    typedef struct packed {
        logic                   sop;
        logic                   eop;
        logic                   val;
        logic [7:0]             vbc;
        logic [NARROW_BITS-1:0] data;
    } narrow_beat_t;

    typedef struct packed {
        logic                 sop;
        logic                 eop;
        logic                 val;
        logic [7:0]           vbc;
        logic [3:0]           id;
        logic [WIDE_BITS-1:0] data;
    } wide_word_t;

    // Only the last beat of a packet may be short.
    function automatic logic beat_legal(input logic [7:0] vbc, input logic eop);
        return (vbc != 8'd0) && (vbc <= 8'(NARROW_BYTES)) &&
               (eop || (vbc == 8'(NARROW_BYTES)));
    endfunction

endpackage

// File: rtl/c3po_sat_cnt.sv
// Counter that increments on inc_i and sticks at all-ones.
module c3po_sat_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/c3po_pack.sv
// Repacks 32-byte narrow beats into 160-byte wide words with a single held output
// register, downstream backpressure and saturating packet/error counters.
module c3po_pack
    import c3po_pkg::*;
#(
    parameter int unsigned CNT_SIZE_P = 8
) (
    input  logic                   sig_clock,
    input  logic                   sig_reset,
    input  logic                   sig_sop,
    input  logic                   sig_eop,
    input  logic                   sig_val,
    input  logic [7:0]             sig_vbc,
    input  logic [NARROW_BITS-1:0] sig_data,
    input  logic [3:0]             sig_cfg_port_id,
    output logic                   sig_ready,
    input  logic                   sig_o_ready,
    output logic                   sig_o_sop,
    output logic                   sig_o_eop,
    output logic                   sig_o_val,
    output logic [7:0]             sig_o_vbc,
    output logic [3:0]             sig_o_id,
    output logic [WIDE_BITS-1:0]   sig_o_data,
    output logic [CNT_SIZE_P-1:0]  sig_pkt_cnt,
    output logic [CNT_SIZE_P-1:0]  sig_err_cnt,
    output logic                   sig_idle
);

    state_e                 state_q;
    logic [2:0]             idx_q;
    logic                   first_q;
    logic [3:0]             id_q;
    logic [NARROW_BITS-1:0] acc_q [BEATS_P-1];
    wide_word_t             word_q;

    narrow_beat_t         beat;
    logic                 accept, drain, legal, err, complete;
    logic [2:0]           wr_idx;
    logic [7:0]           word_vbc;
    logic [WIDE_BITS-1:0] word_data;

    assign beat      = '{sop: sig_sop, eop: sig_eop, val: sig_val, vbc: sig_vbc, data: sig_data};
    assign sig_ready = !word_q.val || sig_o_ready;
    assign accept    = beat.val && sig_ready;
    assign drain     = word_q.val && sig_o_ready;
    assign legal     = beat_legal(beat.vbc, beat.eop);

    assign err = accept && (!legal || ((state_q == IDLE) && !beat.sop) ||
                            ((state_q == IN_PKT) && beat.sop));

    // A sop beat always restarts at slot 0, even when it aborts a packet in flight.
    assign wr_idx   = beat.sop ? 3'd0 : idx_q;
    assign complete = accept && legal && (beat.sop || (state_q == IN_PKT)) &&
                      (beat.eop || (wr_idx == 3'(BEATS_P - 1)));
    assign word_vbc = {wr_idx, 5'd0} + beat.vbc;

    always_comb begin
        word_data = '0;
        for (int k = 0; k < BEATS_P - 1; k++) begin
            if (k < int'(wr_idx)) word_data[k*NARROW_BITS +: NARROW_BITS] = acc_q[k];
        end
        for (int k = 0; k < BEATS_P; k++) begin
            if (k == int'(wr_idx)) word_data[k*NARROW_BITS +: NARROW_BITS] = beat.data;
        end
        // Bytes past the valid count are forced to zero, including the tail of the last beat.
        for (int b = 0; b < WIDE_BYTES; b++) begin
            if (b >= int'(word_vbc)) word_data[b*8 +: 8] = 8'd0;
        end
    end

    always_ff @(posedge sig_clock) begin
        if (sig_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            first_q <= 1'b0;
            id_q    <= '0;
            word_q  <= '0;
            for (int k = 0; k < BEATS_P - 1; k++) acc_q[k] <= '0;
        end else begin
            if (drain) word_q.val <= 1'b0;
            if (complete) begin
                word_q <= '{sop: beat.sop || first_q, eop: beat.eop, val: 1'b1, vbc: word_vbc,
                            id: beat.sop ? sig_cfg_port_id : id_q, data: word_data};
            end
            if (accept) begin
                if (!legal) begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end else if (beat.sop) begin
                    id_q <= sig_cfg_port_id;
                    if (beat.eop) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                    end else begin
                        state_q  <= IN_PKT;
                        idx_q    <= 3'd1;
                        first_q  <= 1'b1;
                        acc_q[0] <= beat.data;
                    end
                end else if (state_q == IN_PKT) begin
                    if (complete) begin
                        idx_q   <= '0;
                        first_q <= 1'b0;
                        if (beat.eop) state_q <= IDLE;
                    end else begin
                        acc_q[idx_q[1:0]] <= beat.data;
                        idx_q             <= idx_q + 3'd1;
                    end
                end
            end
        end
    end

    assign sig_o_sop  = word_q.sop;
    assign sig_o_eop  = word_q.eop;
    assign sig_o_val  = word_q.val;
    assign sig_o_vbc  = word_q.vbc;
    assign sig_o_id   = word_q.id;
    assign sig_o_data = word_q.data;
    assign sig_idle   = (state_q == IDLE) && !word_q.val && (idx_q == 3'd0);

    c3po_sat_cnt #(
        .Width(CNT_SIZE_P)
    ) u_pkt_cnt (
        .clk_i(sig_clock),
        .rst_i(sig_reset),
        .inc_i(drain && word_q.eop),
        .cnt_o(sig_pkt_cnt)
    );

    c3po_sat_cnt #(
        .Width(CNT_SIZE_P)
    ) u_err_cnt (
        .clk_i(sig_clock),
        .rst_i(sig_reset),
        .inc_i(err),
        .cnt_o(sig_err_cnt)
    );

endmodule

// File: tb/tb_c3po_pack.sv
// Bench for c3po_pack: byte-queue packet model, single-beat vector table and directed sequences.
module tb_c3po_pack;
    import c3po_pkg::*;

    localparam int CNT = 8;
    localparam int CNT_MAX = (1 << CNT) - 1;

    logic                   clk = 1'b0;
    logic                   sig_reset, sig_sop, sig_eop, sig_val, sig_o_ready;
    logic [7:0]             sig_vbc;
    logic [NARROW_BITS-1:0] sig_data;
    logic [3:0]             sig_cfg_port_id;
    logic                   sig_ready, sig_o_sop, sig_o_eop, sig_o_val, sig_idle;
    logic [7:0]             sig_o_vbc;
    logic [3:0]             sig_o_id;
    logic [WIDE_BITS-1:0]   sig_o_data;
    logic [CNT-1:0]         sig_pkt_cnt, sig_err_cnt;

    c3po_pack #(
        .CNT_SIZE_P(CNT)
    ) dut (
        .sig_clock(clk),
        .sig_reset(sig_reset),
        .sig_sop(sig_sop),
        .sig_eop(sig_eop),
        .sig_val(sig_val),
        .sig_vbc(sig_vbc),
        .sig_data(sig_data),
        .sig_cfg_port_id(sig_cfg_port_id),
        .sig_ready(sig_ready),
        .sig_o_ready(sig_o_ready),
        .sig_o_sop(sig_o_sop),
        .sig_o_eop(sig_o_eop),
        .sig_o_val(sig_o_val),
        .sig_o_vbc(sig_o_vbc),
        .sig_o_id(sig_o_id),
        .sig_o_data(sig_o_data),
        .sig_pkt_cnt(sig_pkt_cnt),
        .sig_err_cnt(sig_err_cnt),
        .sig_idle(sig_idle)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    typedef struct {
        bit                   sop;
        bit                   eop;
        int                   vbc;
        bit [3:0]             id;
        logic [WIDE_BITS-1:0] data;
    } word_t;

    // Packet-level reference model: bytes collected per packet, flushed every 160 bytes or at eop.
    word_t       exp_q[$];
    byte unsigned cur[$];
    bit          in_pkt, first;
    bit [3:0]    m_id;
    int          m_err, m_pkt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [WIDE_BITS-1:0] act,
                            input logic [WIDE_BITS-1:0] exp);
        nvec++;
        if (act !== exp) begin
            int fb = 0;
            for (int b = WIDE_BYTES - 1; b >= 0; b--) begin
                if (act[b*8 +: 8] !== exp[b*8 +: 8]) fb = b;
            end
            nfail++;
            $display("FAIL %s: byte %0d got %h, expected %h (t=%0t)", name, fb,
                     act[fb*8 +: 8], exp[fb*8 +: 8], $time);
        end
    endtask

    function automatic logic [NARROW_BITS-1:0] rnd256();
        logic [NARROW_BITS-1:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic err_inc();
        if (m_err < CNT_MAX) m_err++;
    endtask

    task automatic model_beat(input bit sop, input bit eop, input int vbc,
                              input logic [NARROW_BITS-1:0] data, input bit [3:0] id);
        word_t w;
        bit legal = (vbc >= 1) && (vbc <= 32) && (eop || vbc == 32);
        if (!legal) begin
            err_inc();
            in_pkt = 0;
            cur.delete();
            return;
        end
        if (sop) begin
            if (in_pkt) err_inc();
            in_pkt = 1;
            first = 1;
            m_id = id;
            cur.delete();
        end else if (!in_pkt) begin
            err_inc();
            return;
        end
        for (int b = 0; b < vbc; b++) cur.push_back(data[b*8 +: 8]);
        if (eop || cur.size() == WIDE_BYTES) begin
            w.data = '0;
            for (int b = 0; b < cur.size(); b++) w.data[b*8 +: 8] = cur[b];
            w.vbc = cur.size();
            w.sop = first;
            w.eop = eop;
            w.id = m_id;
            exp_q.push_back(w);
            cur.delete();
            first = 0;
            if (eop) in_pkt = 0;
        end
    endtask

    // Drives one cycle of inputs, checks DUT state against the model, then advances the model.
    task automatic cycle(input bit val, input bit sop, input bit eop, input int vbc,
                         input logic [NARROW_BITS-1:0] data, input bit [3:0] id, input bit ordy);
        bit m_ready;
        sig_val = val;
        sig_sop = sop;
        sig_eop = eop;
        sig_vbc = 8'(vbc);
        sig_data = data;
        sig_cfg_port_id = id;
        sig_o_ready = ordy;
        #1;
        m_ready = (exp_q.size() == 0) || ordy;
        chk("ready", sig_ready, m_ready);
        chk("o_val", sig_o_val, exp_q.size() != 0);
        if (exp_q.size() != 0 && sig_o_val) begin
            chk("o_vbc", sig_o_vbc, exp_q[0].vbc);
            chk("o_sop", sig_o_sop, exp_q[0].sop);
            chk("o_eop", sig_o_eop, exp_q[0].eop);
            chk("o_id", sig_o_id, exp_q[0].id);
            chk_data("o_data", sig_o_data, exp_q[0].data);
        end
        chk("pkt_cnt", sig_pkt_cnt, m_pkt);
        chk("err_cnt", sig_err_cnt, m_err);
        chk("idle", sig_idle, !in_pkt && exp_q.size() == 0);
        if (exp_q.size() != 0 && ordy) begin
            if (exp_q[0].eop && m_pkt < CNT_MAX) m_pkt++;
            void'(exp_q.pop_front());
        end
        if (val && m_ready) model_beat(sop, eop, vbc, data, id);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sop, input bit eop, input int vbc, input bit [3:0] id,
                        input bit ordy);
        cycle(1'b1, sop, eop, vbc, rnd256(), id, ordy);
    endtask

    task automatic idle_cyc(input bit ordy);
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 4'h0, ordy);
    endtask

    task automatic do_reset();
        sig_reset = 1'b1;
        sig_val = 1'b0;
        sig_sop = 1'b0;
        sig_eop = 1'b0;
        sig_vbc = '0;
        sig_data = '0;
        sig_cfg_port_id = '0;
        sig_o_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        sig_reset = 1'b0;
        exp_q.delete();
        cur.delete();
        in_pkt = 0;
        first = 0;
        m_err = 0;
        m_pkt = 0;
        #1;
        chk("rst_idle", sig_idle, 1'b1);
        chk("rst_ready", sig_ready, 1'b1);
        chk("rst_o_val", sig_o_val, 1'b0);
        chk("rst_o_vbc", sig_o_vbc, 0);
        chk("rst_pkt", sig_pkt_cnt, 0);
        chk("rst_err", sig_err_cnt, 0);
    endtask

    typedef struct {
        bit       sop;
        bit       eop;
        int       vbc;
        bit [3:0] id;
        bit       exp_val;
        int       exp_vbc;
        int       exp_derr;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   exp_err;

        tbl[0] = '{1, 1, 1, 4'hA, 1, 1, 0};
        tbl[1] = '{1, 1, 32, 4'h5, 1, 32, 0};
        tbl[2] = '{1, 1, 0, 4'h1, 0, 0, 1};
        tbl[3] = '{1, 1, 33, 4'h2, 0, 0, 1};
        tbl[4] = '{0, 1, 7, 4'h3, 0, 0, 1};
        tbl[5] = '{1, 1, 17, 4'hF, 1, 17, 0};
        tbl[6] = '{1, 0, 31, 4'h4, 0, 0, 1};

        do_reset();
        exp_err = 0;
        foreach (tbl[i]) begin
            beat(tbl[i].sop, tbl[i].eop, tbl[i].vbc, tbl[i].id, 1'b1);
            exp_err += tbl[i].exp_derr;
            chk("tbl_val", sig_o_val, tbl[i].exp_val);
            if (tbl[i].exp_val) begin
                chk("tbl_vbc", sig_o_vbc, tbl[i].exp_vbc);
                chk("tbl_id", sig_o_id, tbl[i].id);
                chk("tbl_sop", sig_o_sop, 1'b1);
                chk("tbl_eop", sig_o_eop, 1'b1);
            end
            chk("tbl_err", sig_err_cnt, exp_err);
            idle_cyc(1'b1);
        end

        // 160-byte packet in five full beats
        do_reset();
        beat(1, 0, 32, 4'h5, 1);
        for (int i = 0; i < 3; i++) beat(0, 0, 32, 4'h5, 1);
        beat(0, 1, 32, 4'h5, 1);
        chk("p160_val", sig_o_val, 1'b1);
        chk("p160_vbc", sig_o_vbc, 160);
        chk("p160_sop", sig_o_sop, 1'b1);
        chk("p160_eop", sig_o_eop, 1'b1);
        idle_cyc(1'b1);
        chk("p160_pkt", sig_pkt_cnt, 1);

        // 200-byte packet: 160 + 40
        do_reset();
        beat(1, 0, 32, 4'h9, 1);
        for (int i = 0; i < 4; i++) beat(0, 0, 32, 4'h9, 1);
        chk("p200_w1_vbc", sig_o_vbc, 160);
        chk("p200_w1_sop", sig_o_sop, 1'b1);
        chk("p200_w1_eop", sig_o_eop, 1'b0);
        beat(0, 0, 32, 4'h9, 1);
        beat(0, 1, 8, 4'h9, 1);
        chk("p200_w2_vbc", sig_o_vbc, 40);
        chk("p200_w2_sop", sig_o_sop, 1'b0);
        chk("p200_w2_eop", sig_o_eop, 1'b1);
        chk("p200_w2_id", sig_o_id, 4'h9);
        chk("p200_upper_zero", |sig_o_data[WIDE_BITS-1:320], 1'b0);
        idle_cyc(1'b1);

        // Downstream stall on a held word, then release with no bubble
        do_reset();
        beat(1, 0, 32, 4'h2, 0);
        for (int i = 0; i < 3; i++) beat(0, 0, 32, 4'h2, 0);
        beat(0, 1, 32, 4'h2, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 1, 1, 20, rnd256(), 4'h7, 0);
            chk("bp_ready", sig_ready, 1'b0);
            chk("bp_vbc", sig_o_vbc, 160);
        end
        cycle(1, 1, 1, 20, rnd256(), 4'h7, 1);
        chk("bp_next_val", sig_o_val, 1'b1);
        chk("bp_next_vbc", sig_o_vbc, 20);
        chk("bp_next_id", sig_o_id, 4'h7);
        idle_cyc(1'b1);
        chk("bp_pkt", sig_pkt_cnt, 2);

        // Protocol errors
        do_reset();
        beat(0, 0, 32, 4'h1, 1);
        beat(1, 0, 32, 4'h1, 1);
        beat(0, 0, 16, 4'h1, 1);
        beat(1, 1, 0, 4'h1, 1);
        chk("err_cnt3", sig_err_cnt, 3);
        chk("err_idle", sig_idle, 1'b1);
        chk("err_no_word", sig_o_val, 1'b0);

        // Reset mid-packet discards the partial data
        beat(1, 0, 32, 4'h3, 1);
        beat(0, 0, 32, 4'h3, 1);
        beat(0, 0, 32, 4'h3, 1);
        do_reset();
        beat(1, 1, 12, 4'h6, 1);
        chk("mid_rst_vbc", sig_o_vbc, 12);
        chk("mid_rst_id", sig_o_id, 4'h6);
        idle_cyc(1'b1);
        chk("mid_rst_pkt", sig_pkt_cnt, 1);

        // Error counter saturation
        for (int i = 0; i < 300; i++) beat(0, 1, 5, 4'h0, 1);
        chk("err_sat", sig_err_cnt, CNT_MAX);

        // Randomized traffic with occasional corruption and backpressure
        do_reset();
        begin
            int left = 0;
            bit start = 0;
            for (int c = 0; c < 3000; c++) begin
                bit val, sop, eop, ordy, corrupt, m_ready;
                int vbc;
                if (left == 0) begin
                    left = $urandom_range(1, 400);
                    start = 1;
                end
                val = $urandom_range(0, 7) != 0;
                ordy = $urandom_range(0, 3) != 0;
                sop = start;
                vbc = (left > 32) ? 32 : left;
                eop = left <= 32;
                corrupt = $urandom_range(0, 29) == 0;
                if (corrupt) begin
                    case ($urandom_range(0, 2))
                        0: vbc = $urandom_range(0, 40);
                        1: sop = !sop;
                        default: eop = !eop;
                    endcase
                end
                m_ready = (exp_q.size() == 0) || ordy;
                cycle(val, sop, eop, vbc, rnd256(), 4'($urandom), ordy);
                if (val && m_ready) begin
                    left = (corrupt || eop) ? 0 : left - vbc;
                    start = 0;
                end
            end
        end
        for (int i = 0; i < 3; i++) idle_cyc(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
